muldiv_sequencer: RTL and testbench

// - Multi-cycle controller for RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) beside the single-cycle ALU.
// - Decode steers funct7=0000001 R-type ops here; EX stalls while busy.
// - Runs an iterative shift-add multiply / restoring divide through an FSM with valid/ready handshakes on both sides.

---
 rtl/muldiv_sequencer.sv | 160 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiply, restoring divide, valid/ready on both sides.
// Build option MULDIV_FAST_MUL_EN: multiplies use a single combinational product; divides stay iterative.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             busy
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         op;
   logic               neg_q;
   logic               neg_r;
   logic               special;
   logic [WIDTH-1:0]   special_val;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [2*WIDTH-1:0] prod;

   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v, input logic is_signed);
      return (is_signed && v < 0) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   logic               a_signed;
   logic               b_signed;
   logic               div_zero;
   logic               div_ovf;
   logic               accept;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] prod_fixed;
   logic [2*WIDTH-1:0] prod_init;
   logic [2*WIDTH-1:0] prod_step;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quo_next;

   // MULHSU is the only op with mixed signedness: rs1 signed, rs2 unsigned.
   assign a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
   assign b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
   assign a_mag    = magnitude(src_a, a_signed);
   assign b_mag    = magnitude(src_b, b_signed);
   assign div_zero = (src_b == '0);
   assign div_ovf  = ~funct3[0] && (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&src_b);

   assign accept      = (state == IDLE) && start_valid && !flush;
   assign start_ready = (state == IDLE);
   assign busy        = (state != IDLE);

   assign prod_fixed = apply_sign_wide(prod, neg_q);
   assign div_shift  = {rem, quo[WIDTH-1]};
   assign div_ge     = (div_shift >= {1'b0, addend});
   assign rem_next   = div_ge ? (div_shift[WIDTH-1:0] - addend) : div_shift[WIDTH-1:0];
   assign quo_next   = {quo[WIDTH-2:0], div_ge};

`ifdef MULDIV_FAST_MUL_EN
   localparam logic [CNT_W-1:0] MUL_ITERS = '0;
   assign prod_init = (2*WIDTH)'(a_mag) * (2*WIDTH)'(b_mag);
   assign prod_step = prod;
`else
   localparam logic [CNT_W-1:0] MUL_ITERS = ITERS;
   logic [WIDTH:0] mul_sum;
   assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, addend} : '0);
   assign prod_init = {{WIDTH{1'b0}}, b_mag};
   assign prod_step = {mul_sum, prod[WIDTH-1:1]};
`endif

   // Datapath registers: loaded at accept, stepped once per iteration; no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         op          <= funct3[1:0];
         neg_q       <= (a_signed & src_a[WIDTH-1]) ^ (b_signed & src_b[WIDTH-1]);
         neg_r       <= a_signed & src_a[WIDTH-1];
         special     <= funct3[2] & (div_zero | div_ovf);
         special_val <= div_zero ? (funct3[1] ? src_a : '1) : (funct3[1] ? '0 : src_a);
         addend      <= funct3[2] ? b_mag : a_mag;
         rem         <= '0;
         quo         <= a_mag;
         prod        <= prod_init;
      end else if (state == MUL && cnt != '0) begin
         prod <= prod_step;
      end else if (state == DIV && cnt != '0) begin
         rem <= rem_next;
         quo <= quo_next;
      end
   end

   // Control: the iteration state finishes one edge after the counter reaches zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         result       <= '0;
         result_valid <= 1'b0;
      end else if (flush && state != IDLE) begin
         state        <= IDLE;
         result_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= funct3[2] ? DIV : MUL;
                  cnt   <= funct3[2] ? ((div_zero || div_ovf) ? '0 : ITERS) : MUL_ITERS;
               end
            end
            MUL: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  result       <= (op == 2'b00) ? prod_fixed[WIDTH-1:0] : prod_fixed[2*WIDTH-1:WIDTH];
                  result_valid <= 1'b1;
                  state        <= DONE;
               end
            end
            DIV: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  result       <= special ? special_val :
                                  (op[1] ? apply_sign(rem, neg_r) : apply_sign(quo, neg_q));
                  result_valid <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               if (result_ready) begin
                  state        <= IDLE;
                  result_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table of RV32M ops plus backpressure, flush and reset sequences.
module tb_muldiv_sequencer;
   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int ML = 1;
`else
   localparam int ML = 33;
`endif
   localparam int NV = 21;

   logic         clk = 1'b0;
   logic         reset, flush, start_valid, result_ready;
   logic         start_ready, result_valid, busy;
   logic [2:0]   funct3;
   logic [W-1:0] src_a, src_b, result;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .start_valid(start_valid), .start_ready(start_ready),
      .funct3(funct3), .src_a(src_a), .src_b(src_b),
      .result(result), .result_valid(result_valid), .result_ready(result_ready),
      .busy(busy)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[NV];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Entered at the negedge after the accept edge; waits, checks, then hands the result off.
   task automatic wait_result(input string nm, input logic [31:0] exp, input int lat);
      int n = 0;
      int i = 0;
      while (n == 0 && i < 100) begin
         i++;
         @(posedge clk);
         @(negedge clk);
         if (result_valid) n = i;
      end
      check({nm, " latency"}, 32'(n), 32'(lat));
      check({nm, " result"}, result, exp);
      result_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      result_ready = 1'b0;
      check({nm, " busy after handoff"}, 32'(busy), 32'd0);
      check({nm, " valid after handoff"}, 32'(result_valid), 32'd0);
   endtask

   task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      check({nm, " start_ready"}, 32'(start_ready), 32'd1);
      funct3 = f; src_a = a; src_b = b; start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
   endtask

   task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      issue(nm, f, a, b);
      wait_result(nm, exp, lat);
   endtask

   task automatic count_valid(input string nm, input int cycles);
      int hits = 0;
      repeat (cycles) begin
         @(posedge clk);
         @(negedge clk);
         if (result_valid) hits++;
      end
      check({nm, " valid rises"}, 32'(hits), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
      funct3 = '0; src_a = '0; src_b = '0;

      vecs[0]  = '{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, ML};
      vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML};
      vecs[2]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, ML};
      vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,         32'hFFFFFFFF, ML};
      vecs[4]  = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, ML};
      vecs[5]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, ML};
      vecs[6]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, ML};
      vecs[7]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, ML};
      vecs[8]  = '{3'b100, 32'd100,       32'd0,         32'hFFFFFFFF, 1};
      vecs[9]  = '{3'b111, 32'd100,       32'd0,         32'd100,      1};
      vecs[10] = '{3'b101, 32'd100,       32'd0,         32'hFFFFFFFF, 1};
      vecs[11] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      vecs[12] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
      vecs[13] = '{3'b110, 32'hFFFFFFF9, 32'd2,         32'hFFFFFFFF, 33};
      vecs[14] = '{3'b101, 32'hFFFFFFF9, 32'd2,         32'h7FFFFFFC, 33};
      vecs[15] = '{3'b100, 32'hFFFFFFF9, 32'd2,         32'hFFFFFFFD, 33};
      vecs[16] = '{3'b110, 32'd7,         32'hFFFFFFFE, 32'd1,        33};
      vecs[17] = '{3'b100, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 33};
      vecs[18] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
      vecs[19] = '{3'b111, 32'd100,       32'd7,         32'd2,        33};
      vecs[20] = '{3'b110, 32'd0,         32'd0,         32'd0,        1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset result", result, 32'd0);
      check("reset result_valid", 32'(result_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset start_ready", 32'(start_ready), 32'd1);
      reset = 1'b0;

      for (int i = 0; i < NV; i++)
         run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

      // Backpressure: hold DONE for ten cycles, then hand off with a new request already waiting.
      issue("bp", 3'b101, 32'd100, 32'd7);
      begin
         int n = 0;
         int i = 0;
         while (n == 0 && i < 100) begin
            i++;
            @(posedge clk);
            @(negedge clk);
            if (result_valid) n = i;
         end
         check("bp latency", 32'(n), 32'd33);
      end
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("bp hold%0d result", k), result, 32'd14);
         check($sformatf("bp hold%0d valid", k), 32'(result_valid), 32'd1);
         check($sformatf("bp hold%0d start_ready", k), 32'(start_ready), 32'd0);
      end
      funct3 = 3'b000; src_a = 32'd3; src_b = 32'd5; start_valid = 1'b1; result_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      result_ready = 1'b0;
      check("bp handoff busy", 32'(busy), 32'd0);
      check("bp handoff start_ready", 32'(start_ready), 32'd1);
      check("bp handoff valid", 32'(result_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      check("bp next accepted", 32'(busy), 32'd1);
      wait_result("bp next", 32'd15, ML);

      // Flush sampled at edge 5 of a divide.
      issue("flush_div", 3'b100, 32'd1000, 32'd3);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("flush_div pre valid", 32'(result_valid), 32'd0);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      check("flush_div busy", 32'(busy), 32'd0);
      check("flush_div start_ready", 32'(start_ready), 32'd1);
      count_valid("flush_div", 40);
      run_op("after_flush", 3'b100, 32'd1000, 32'd3, 32'd333, 33);

      // Reset sampled at edge 5 of a multiply.
      issue("reset_mul", 3'b000, 32'd9, 32'd9);
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_mul busy", 32'(busy), 32'd0);
      check("reset_mul result", result, 32'd0);
      count_valid("reset_mul", 40);
      run_op("after_reset", 3'b000, 32'h12345678, 32'h00000010, 32'h23456780, ML);

      // Flush in IDLE blocks acceptance.
      @(negedge clk);
      funct3 = 3'b100; src_a = 32'd50; src_b = 32'd5; start_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0; flush = 1'b0;
      check("idle_flush busy", 32'(busy), 32'd0);
      count_valid("idle_flush", 5);

      // Flush in DONE discards the result.
      issue("flush_done", 3'b111, 32'd77, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("flush_done valid", 32'(result_valid), 32'd1);
      check("flush_done result", result, 32'd77);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      check("flush_done after valid", 32'(result_valid), 32'd0);
      check("flush_done after busy", 32'(busy), 32'd0);
      run_op("after_flush_done", 3'b101, 32'd77, 32'd7, 32'd11, 33);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
